// File: rtl/cpu_pkg.sv
// Shared types and defaults for the memory arbiter: FSM state encoding and
// the default abort timeout.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2
  } arb_state_e;

  localparam int unsigned MEM_ARB_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto one memory port with timeout abort.
// Build option MEM_ARB_RR_EN: round-robin tie break instead of fixed ls-over-if priority.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = MEM_ARB_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_be,
  output logic        ls_ready,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  // Handshake: a requester raises req with its command and holds it until its
  // ready pulse; ready/err/rdata are valid only in that one pulse cycle. The
  // memory side sees mem_req held for the whole busy state and completes it by
  // a single-cycle mem_ready with mem_rdata valid in the same cycle.

  // Busy cycle whose count is this value, without mem_ready, is the last one.
  localparam logic [7:0] TERM_CNT = 8'(TIMEOUT - 2);

  arb_state_e state;
  arb_state_e state_next;
  logic [7:0] cnt;
  logic       busy;
  logic       grant_if;
  logic       grant_ls;
  logic       done_ok;
  logic       done_to;
  logic       finish;

`ifdef MEM_ARB_RR_EN
  logic rr_ls;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ls <= 1'b1;
    end else if (grant_ls) begin
      rr_ls <= 1'b0;
    end else if (grant_if) begin
      rr_ls <= 1'b1;
    end
  end

  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (state == IDLE) begin
      if (ls_req && if_req) begin
        grant_ls = rr_ls;
        grant_if = !rr_ls;
      end else begin
        grant_ls = ls_req;
        grant_if = if_req;
      end
    end
  end
`else
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (state == IDLE) begin
      grant_ls = ls_req;
      grant_if = if_req && !ls_req;
    end
  end
`endif

  assign busy    = (state != IDLE);
  assign done_ok = busy && mem_ready;
  // mem_ready on the terminal count wins over the abort.
  assign done_to = busy && !mem_ready && (cnt == TERM_CNT);
  assign finish  = done_ok || done_to;
  assign mem_req = busy;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_ls) begin
          state_next = BUSY_LS;
        end else if (grant_if) begin
          state_next = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_LS: begin
        if (finish) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (grant_ls || grant_if) begin
      cnt <= 8'd0;
    end else if (busy && !mem_ready) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Command is captured only on the grant edge and frozen for the busy state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_be    <= 4'd0;
    end else if (grant_ls) begin
      mem_we    <= ls_we;
      mem_addr  <= ls_addr;
      mem_wdata <= ls_wdata;
      mem_be    <= ls_be;
    end else if (grant_if) begin
      mem_we    <= 1'b0;
      mem_addr  <= if_addr;
      mem_wdata <= 32'd0;
      mem_be    <= 4'hF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_ready <= 1'b0;
      if_err   <= 1'b0;
      if_rdata <= 32'd0;
      ls_ready <= 1'b0;
      ls_err   <= 1'b0;
      ls_rdata <= 32'd0;
    end else begin
      if_ready <= (state == BUSY_IF) && finish;
      if_err   <= (state == BUSY_IF) && done_to;
      ls_ready <= (state == BUSY_LS) && finish;
      ls_err   <= (state == BUSY_LS) && done_to;
      if ((state == BUSY_IF) && finish) begin
        if_rdata <= done_ok ? mem_rdata : 32'd0;
      end
      // Stores and aborts return zero data.
      if ((state == BUSY_LS) && finish) begin
        ls_rdata <= (done_ok && !mem_we) ? mem_rdata : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (TIMEOUT=4) with a transaction-level model.
// Honours MEM_ARB_RR_EN for the expected tie-break order.
module tb_mem_arbiter;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_be;
  logic        ls_ready;
  logic [31:0] ls_rdata;
  logic        ls_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  // Model state: who was granted last, and the rdata each requester should hold.
  bit          last_ls = 1'b0;
  logic [31:0] m_if = 32'd0;
  logic [31:0] m_ls = 32'd0;
  logic [31:0] exp_q[$];

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
    .ls_ready(ls_ready), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // Entered at a negedge with the DUT idle (or in a ready cycle). d = cycle of
  // mem_req in which mem_ready is raised (0 = never).
  task automatic run_txn(input bit rq_if, input bit rq_ls, input bit hold,
                         input logic [31:0] ia, input logic [31:0] la, input logic [31:0] lwd,
                         input bit lwe, input logic [3:0] lbe, input int d, input logic [31:0] rd);
    bit          win_ls;
    bit          ok;
    int          nb;
    logic [31:0] e_addr;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] want_d;
    if_req = rq_if; ls_req = rq_ls; if_addr = ia; ls_addr = la;
    ls_wdata = lwd; ls_we = lwe; ls_be = lbe; mem_ready = 1'b0;
    if (rq_ls && rq_if) begin
`ifdef MEM_ARB_RR_EN
      win_ls = !last_ls;
`else
      win_ls = 1'b1;
`endif
    end else begin
      win_ls = rq_ls;
    end
    last_ls = win_ls;
    e_addr = win_ls ? la : ia;
    e_we   = win_ls ? lwe : 1'b0;
    e_be   = win_ls ? lbe : 4'hF;
    ok = (d >= 1) && (d <= TO - 1);
    nb = ok ? d : TO - 1;
    exp_q.push_back((!ok || (win_ls && lwe)) ? 32'd0 : rd);
    for (int k = 1; k <= nb; k++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, mem_we, mem_be, mem_addr, if_ready, ls_ready} !== {1'b1, e_we, e_be, e_addr, 2'b00}) begin
        failures++;
        $display("FAIL busy_cmd cyc=%0d: got req=%b we=%b be=%h addr=%h rdy=%b%b, want req=1 we=%b be=%h addr=%h rdy=00",
                 k, mem_req, mem_we, mem_be, mem_addr, if_ready, ls_ready, e_we, e_be, e_addr);
      end
      if (win_ls && lwe) begin
        checks++;
        if (mem_wdata !== lwd) begin
          failures++;
          $display("FAIL busy_wdata cyc=%0d: got %h want %h", k, mem_wdata, lwd);
        end
      end
      mem_ready = (k == d);
      mem_rdata = (k == d) ? rd : $urandom;
      if_addr = $urandom; ls_addr = $urandom; ls_wdata = $urandom;
      ls_be = 4'($urandom); ls_we = 1'($urandom);
      if (!hold) begin
        if_req = 1'($urandom);
        ls_req = 1'($urandom);
      end
    end
    @(negedge clk);
    want_d = exp_q.pop_front();
    if (win_ls) m_ls = want_d; else m_if = want_d;
    checks++;
    if ({mem_req, if_ready, if_err, ls_ready, ls_err} !== {1'b0, !win_ls, !win_ls && !ok, win_ls, win_ls && !ok}) begin
      failures++;
      $display("FAIL done_flags: got req=%b ifr=%b ife=%b lsr=%b lse=%b, want req=0 ifr=%b ife=%b lsr=%b lse=%b",
               mem_req, if_ready, if_err, ls_ready, ls_err, !win_ls, !win_ls && !ok, win_ls, win_ls && !ok);
    end
    checks++;
    if ({if_rdata, ls_rdata} !== {m_if, m_ls}) begin
      failures++;
      $display("FAIL done_rdata: got if=%h ls=%h want if=%h ls=%h", if_rdata, ls_rdata, m_if, m_ls);
    end
    mem_ready = 1'b0;
    if (!hold) begin
      if_req = 1'b0;
      ls_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_ready, if_rdata, if_err, ls_ready, ls_rdata, ls_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h be=%h ifr=%b ifd=%h lsr=%b lsd=%h, want all 0",
               mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_ready, if_rdata, ls_ready, ls_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req, if_ready, ls_ready} !== 3'b000) begin
      failures++;
      $display("FAIL reset_release_idle: got req=%b ifr=%b lsr=%b want 000", mem_req, if_ready, ls_ready);
    end
  endtask

  // Idle cycles with mem_ready toggling: must not produce any response.
  task automatic test_idle_ignore(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, if_ready, if_err, ls_ready, ls_err} !== 5'b0) begin
        failures++;
        $display("FAIL idle_quiet: got req=%b ifr=%b ife=%b lsr=%b lse=%b want 0",
                 mem_req, if_ready, if_err, ls_ready, ls_err);
      end
      checks++;
      if ({if_rdata, ls_rdata} !== {m_if, m_ls}) begin
        failures++;
        $display("FAIL idle_rdata_hold: got if=%h ls=%h want if=%h ls=%h", if_rdata, ls_rdata, m_if, m_ls);
      end
      mem_ready = 1'($urandom);
      mem_rdata = $urandom;
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_store();
    run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h2000, 32'hDEADBEEF, 1'b1, 4'b0011, 2, 32'h12345678);
    checks++;
    if (ls_rdata !== 32'd0) begin
      failures++;
      $display("FAIL store_rdata: got %h want 00000000", ls_rdata);
    end
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h4000, 32'h0, 1'b0, 4'hF, 0, 32'hCAFEF00D);
    test_idle_ignore(2);
  endtask

  task automatic test_fetch();
    run_txn(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 1'b0, 4'h0, 2, 32'h00500093);
    checks++;
    if (if_rdata !== 32'h00500093) begin
      failures++;
      $display("FAIL fetch_rdata: got %h want 00500093", if_rdata);
    end
  endtask

  task automatic test_terminal_count();
    // mem_ready on the last allowed busy cycle completes normally.
    run_txn(1'b1, 1'b0, 1'b0, 32'h180, 32'h0, 32'h0, 1'b0, 4'h0, TO - 1, 32'hA5A5_0001);
    run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h1800, 32'h0, 1'b0, 4'h5, TO - 1, 32'hA5A5_0002);
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b1, 1'b1, i < 3, 32'h1000 + 32'(i * 4), 32'h8000 + 32'(i * 4), 32'h0, 1'b0, 4'hF,
              1 + (i % 2), $urandom);
    end
  endtask

  task automatic test_reset_mid_busy();
    if_req = 1'b1;
    if_addr = 32'h300;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h300}) begin
      failures++;
      $display("FAIL rst_pre_busy: got req=%b addr=%h want req=1 addr=00000300", mem_req, mem_addr);
    end
    #2 rst = 1'b1;
    #1;
    m_if = 32'd0;
    m_ls = 32'd0;
    last_ls = 1'b0;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_ready, if_rdata, if_err, ls_ready, ls_rdata, ls_err} !== '0) begin
      failures++;
      $display("FAIL rst_async: got req=%b we=%b addr=%h wdata=%h be=%h ifr=%b ifd=%h lsr=%b lsd=%h, want all 0",
               mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_ready, if_rdata, ls_ready, ls_rdata);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, if_ready, if_err} !== 3'b000) begin
        failures++;
        $display("FAIL rst_hold: got req=%b ifr=%b ife=%b want 000", mem_req, if_ready, if_err);
      end
    end
    rst = 1'b0;
    run_txn(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 32'h0, 1'b0, 4'h0, 1, 32'h0BAD_C0DE);
  endtask

  task automatic test_random();
    int  rq;
    bit  hold;
    for (int i = 0; i < 40; i++) begin
      rq = $urandom_range(1, 3);
      hold = (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_txn(rq[0], rq[1], hold, $urandom, $urandom, $urandom, 1'($urandom), 4'($urandom),
              $urandom_range(0, TO + 1), $urandom);
      if (!hold && ($urandom_range(0, 3) == 0)) begin
        test_idle_ignore($urandom_range(1, 2));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'd0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'd0; ls_wdata = 32'd0; ls_be = 4'd0;
    mem_ready = 1'b0; mem_rdata = 32'd0;
    test_reset();
    test_store();
    test_timeout();
    test_fetch();
    test_simultaneous();
    test_idle_ignore(3);
    test_terminal_count();
    test_reset_mid_busy();
    test_random();
    test_idle_ignore(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
